// File: rtl/lane_engine_pkg.sv
// Shared screen geometry, motion defaults and lane helpers for the traffic lane engine.
package lane_engine_pkg;

  localparam int unsigned SCREEN_W_DEF = 640;
  localparam int unsigned SCREEN_H_DEF = 480;
  localparam int unsigned STEP_DEF     = 2;
  localparam int unsigned TICK_DIV_DEF = 250000;
  localparam int unsigned LEVEL_W      = 4;

  typedef enum logic {
    DIR_RIGHT = 1'b0,
    DIR_LEFT  = 1'b1
  } dir_e;

  // Lanes repeat a four-step speed pattern across the screen.
  function automatic int unsigned lane_period_base(input int unsigned base, input int unsigned lane);
    return base + (lane % 4);
  endfunction

  function automatic int unsigned lane_start_x(input int unsigned lane, input int unsigned spacing,
                                               input int unsigned screen_w);
    return (lane * spacing) % screen_w;
  endfunction

endpackage

// File: rtl/lane_mover.sv
// One traffic lane: counts movement ticks against a level-dependent period and steps
// its x-position with wrap-around in a fixed direction.
module lane_mover
  import lane_engine_pkg::*;
#(
  parameter int unsigned X_W         = 10,
  parameter int unsigned SCREEN_W    = SCREEN_W_DEF,
  parameter int unsigned STEP        = STEP_DEF,
  parameter int unsigned PERIOD_BASE = 4,
  parameter int unsigned START_X     = 0,
  parameter dir_e        DIR         = DIR_RIGHT
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               tick,
  input  logic [LEVEL_W-1:0] level,
  output logic [X_W-1:0]     x,
  output logic               moved
);

  localparam int unsigned CNT_W = $clog2(PERIOD_BASE + 1) + 1;
  localparam int unsigned XW1   = X_W + 1;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] period;
  logic             step_now;
  logic [X_W:0]     x_sum;
  logic [X_W:0]     x_next;

  // Period clamps at 1 once the level eats the whole base period.
  always_comb begin
    period = CNT_W'(1);
    if (32'(level) < PERIOD_BASE) begin
      period = CNT_W'(PERIOD_BASE - 32'(level));
    end
  end

  // >= lets a counter left above a freshly shortened period step on the next tick.
  assign cnt_inc  = cnt + CNT_W'(1);
  assign step_now = tick && (cnt_inc >= period);

  always_comb begin
    x_sum  = {1'b0, x} + XW1'(STEP);
    x_next = {1'b0, x};
    if (DIR == DIR_RIGHT) begin
      x_next = (x_sum < XW1'(SCREEN_W)) ? x_sum : x_sum - XW1'(SCREEN_W);
    end else begin
      x_next = ({1'b0, x} >= XW1'(STEP)) ? {1'b0, x} - XW1'(STEP)
                                         : {1'b0, x} + XW1'(SCREEN_W - STEP);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt   <= '0;
      x     <= X_W'(START_X);
      moved <= 1'b0;
    end else begin
      moved <= step_now;
      if (tick) begin
        cnt <= step_now ? '0 : cnt_inc;
      end
      if (step_now) begin
        x <= X_W'(x_next);
      end
    end
  end

endmodule

// File: rtl/lane_engine.sv
// Traffic lane engine: a shared movement-tick prescaler driving NUM_LANES lane movers
// that alternate direction and run faster as the level rises.
module lane_engine
  import lane_engine_pkg::*;
#(
  parameter int unsigned NUM_LANES     = 8,
  parameter int unsigned X_W           = 10,
  parameter int unsigned SCREEN_W      = SCREEN_W_DEF,
  parameter int unsigned STEP          = STEP_DEF,
  parameter int unsigned TICK_DIV      = TICK_DIV_DEF,
  parameter int unsigned BASE_PERIOD   = 4,
  parameter int unsigned START_SPACING = 80
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     pause,
  input  logic [LEVEL_W-1:0]       level,
  output logic [NUM_LANES*X_W-1:0] lane_x,
  output logic [NUM_LANES-1:0]     step_mask,
  output logic                     tick
);

  localparam int unsigned PRE_W = $clog2(TICK_DIV);

  logic [PRE_W-1:0] pre_cnt;
  logic             at_top;

  // Pause gates the tick immediately so a held terminal count never fires.
  assign at_top = (pre_cnt == PRE_W'(TICK_DIV - 1));
  assign tick   = at_top && !pause;

  always_ff @(posedge CLK) begin
    if (RST) begin
      pre_cnt <= '0;
    end else if (!pause) begin
      pre_cnt <= at_top ? '0 : pre_cnt + PRE_W'(1);
    end
  end

  for (genvar i = 0; i < int'(NUM_LANES); i++) begin : g_lane
    lane_mover #(
      .X_W        (X_W),
      .SCREEN_W   (SCREEN_W),
      .STEP       (STEP),
      .PERIOD_BASE(lane_period_base(BASE_PERIOD, 32'(i))),
      .START_X    (lane_start_x(32'(i), START_SPACING, SCREEN_W)),
      .DIR        ((i % 2 == 0) ? DIR_RIGHT : DIR_LEFT)
    ) u_lane (
      .CLK  (CLK),
      .RST  (RST),
      .tick (tick),
      .level(level),
      .x    (lane_x[i*X_W +: X_W]),
      .moved(step_mask[i])
    );
  end

endmodule

// File: tb/tb_lane_engine.sv
// Self-checking bench for lane_engine: directed tick table, wrap, level, pause and reset
// sequences, then a long random run with a lane-0 model and range checks.
module tb_lane_engine;

  localparam int unsigned NL = 4;
  localparam int unsigned XW = 10;
  localparam int unsigned SW = 640;
  localparam int unsigned TD = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic          pause;
  logic          pause_w;
  logic [3:0]    level;
  logic [3:0]    level_w;
  logic [NL*XW-1:0] xa, xb, xc, xd;
  logic [NL-1:0]    ma, mb, mc, md;
  logic             tick_a, tick_b, tick_c, tick_d;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  // A: reference lanes. B/C/D: wrap fixtures, every lane period 1.
  lane_engine #(.NUM_LANES(NL), .X_W(XW), .SCREEN_W(SW), .STEP(2), .TICK_DIV(TD),
                .BASE_PERIOD(1), .START_SPACING(80)) dut_a (
    .CLK(CLK), .RST(RST), .pause(pause), .level(level),
    .lane_x(xa), .step_mask(ma), .tick(tick_a));
  lane_engine #(.NUM_LANES(NL), .X_W(XW), .SCREEN_W(SW), .STEP(2), .TICK_DIV(TD),
                .BASE_PERIOD(1), .START_SPACING(319)) dut_b (
    .CLK(CLK), .RST(RST), .pause(pause_w), .level(level_w),
    .lane_x(xb), .step_mask(mb), .tick(tick_b));
  lane_engine #(.NUM_LANES(NL), .X_W(XW), .SCREEN_W(SW), .STEP(3), .TICK_DIV(TD),
                .BASE_PERIOD(1), .START_SPACING(319)) dut_c (
    .CLK(CLK), .RST(RST), .pause(pause_w), .level(level_w),
    .lane_x(xc), .step_mask(mc), .tick(tick_c));
  lane_engine #(.NUM_LANES(NL), .X_W(XW), .SCREEN_W(SW), .STEP(2), .TICK_DIV(TD),
                .BASE_PERIOD(1), .START_SPACING(1)) dut_d (
    .CLK(CLK), .RST(RST), .pause(pause_w), .level(level_w),
    .lane_x(xd), .step_mask(md), .tick(tick_d));

  typedef struct {
    logic [3:0]  mask;
    int unsigned x0, x1, x2, x3;
  } vec_t;

  vec_t vecs[6];

  function automatic int unsigned lane(input logic [NL*XW-1:0] v, input int i);
    return 32'(v[i*XW +: XW]);
  endfunction

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_lanes(input string name, input int unsigned e0, input int unsigned e1,
                             input int unsigned e2, input int unsigned e3);
    check({name, "_x0"}, lane(xa, 0), e0);
    check({name, "_x1"}, lane(xa, 1), e1);
    check({name, "_x2"}, lane(xa, 2), e2);
    check({name, "_x3"}, lane(xa, 3), e3);
  endtask

  task automatic do_reset();
    RST   = 1'b1;
    pause = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  // Leaves the bench at the negedge where tick is high (bounded).
  task automatic wait_tick(input string name);
    int n = 0;
    while (tick_a !== 1'b1 && n < 40) begin
      @(negedge CLK);
      n++;
    end
    check({name, "_tick_seen"}, 32'(tick_a), 1);
  endtask

  task automatic next_step(input string name);
    wait_tick(name);
    @(negedge CLK);
  endtask

  task automatic pause_test(input int h);
    logic [NL*XW-1:0] held;
    int n;
    do_reset();
    repeat (h) @(negedge CLK);
    pause = 1'b1;
    #1;
    check("pause_gates_tick", 32'(tick_a), 0);
    held = xa;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      check("pause_no_tick", 32'(tick_a), 0);
      check("pause_no_mask", 32'(ma), 0);
      check("pause_hold_x", 32'(xa == held), 1);
    end
    pause = 1'b0;
    n = 1;
    #1;
    while (tick_a !== 1'b1 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    check("resume_tick_latency", 32'(n), TD - 32'(h));
    check("resume_tick", 32'(tick_a), 1);
    @(negedge CLK);
    check("resume_mask", 32'(ma), 32'(4'b0001));
    check("resume_x0", lane(xa, 0), 2);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned x0_m;
    logic        prev_tick;
    int          ticks;
    int          cyc;
    logic        in_range;

    vecs[0] = '{4'b0001,  2, 80, 160, 240};
    vecs[1] = '{4'b0011,  4, 78, 160, 240};
    vecs[2] = '{4'b0101,  6, 78, 162, 240};
    vecs[3] = '{4'b1011,  8, 76, 162, 238};
    vecs[4] = '{4'b0001, 10, 76, 162, 238};
    vecs[5] = '{4'b0111, 12, 74, 164, 238};

    RST     = 1'b1;
    pause   = 1'b0;
    pause_w = 1'b0;
    level   = 4'd0;
    level_w = 4'd15;

    // Reset state and the first six ticks at level 0.
    do_reset();
    check_lanes("reset", 0, 80, 160, 240);
    check("reset_mask", 32'(ma), 0);
    check("reset_tick", 32'(tick_a), 0);
    check("reset_b_x2", lane(xb, 2), 638);
    check("reset_d_x1", lane(xd, 1), 1);
    for (int t = 0; t < 6; t++) begin
      check("tick_low_c0", 32'(tick_a), 0);
      @(negedge CLK);
      check("tick_low_c1", 32'(tick_a), 0);
      check("mask_one_cycle", 32'(ma), 0);
      @(negedge CLK);
      check("tick_low_c2", 32'(tick_a), 0);
      @(negedge CLK);
      check("tick_high_c3", 32'(tick_a), 1);
      check("mask_before_step", 32'(ma), 0);
      @(negedge CLK);
      check("step_mask", 32'(ma), 32'(vecs[t].mask));
      check_lanes("step", vecs[t].x0, vecs[t].x1, vecs[t].x2, vecs[t].x3);
      if (t == 0) begin
        check("wrap_r_step2", lane(xb, 2), 0);
        check("left_b_x1", lane(xb, 1), 317);
        check("wrap_r_step3", lane(xc, 2), 1);
        check("left_c_x1", lane(xc, 1), 316);
        check("wrap_l_step2", lane(xd, 1), 639);
        check("left_d_x3", lane(xd, 3), 1);
        check("right_d_x2", lane(xd, 2), 4);
        check("fast_mask_b", 32'(mb), 32'(4'b1111));
      end
    end

    // Level jump with lane 3 mid-count.
    do_reset();
    next_step("lvl_t1");
    next_step("lvl_t2");
    check("lvl_pre_x3", lane(xa, 3), 240);
    level = 4'd15;
    for (int k = 0; k < 3; k++) begin
      next_step("lvl_fast");
      check("lvl_mask", 32'(ma), 32'(4'b1111));
      check("lvl_x3", lane(xa, 3), 238 - 2 * 32'(k));
      check("lvl_x0", lane(xa, 0), 6 + 2 * 32'(k));
    end
    level = 4'd0;

    // Pause holding mid-period and exactly on the terminal count.
    pause_test(1);
    pause_test(3);

    // Reset coinciding with a tick, with and without pause.
    for (int pz = 1; pz >= 0; pz--) begin
      do_reset();
      next_step("rst_run1");
      next_step("rst_run2");
      next_step("rst_run3");
      wait_tick("rst_at_tick");
      RST   = 1'b1;
      pause = pz[0];
      @(negedge CLK);
      check_lanes("rst_mid", 0, 80, 160, 240);
      check("rst_mid_mask", 32'(ma), 0);
      check("rst_mid_tick", 32'(tick_a), 0);
      check("rst_mid_b_x2", lane(xb, 2), 638);
      RST   = 1'b0;
      pause = 1'b0;
    end

    // Long random run: lane 0 always has period 1, so it steps on every tick.
    do_reset();
    x0_m  = 0;
    ticks = 0;
    cyc   = 0;
    #1;
    prev_tick = tick_a;
    while (ticks < 10000 && cyc < 80000) begin
      @(negedge CLK);
      cyc++;
      if (prev_tick) begin
        x0_m = (x0_m + 2) % SW;
      end
      check("rand_x0_model", lane(xa, 0), x0_m);
      check("rand_mask0", 32'(ma[0]), 32'(prev_tick));
      check("rand_mask_needs_tick", 32'((ma != '0) && !prev_tick), 0);
      in_range = 1'b1;
      for (int i = 0; i < int'(NL); i++) begin
        if (lane(xa, i) >= SW || lane(xb, i) >= SW || lane(xc, i) >= SW || lane(xd, i) >= SW) begin
          in_range = 1'b0;
        end
      end
      check("rand_x_range", 32'(in_range), 1);
      pause = ($urandom_range(0, 7) == 0);
      level = 4'($urandom_range(0, 15));
      #1;
      prev_tick = tick_a;
      if (tick_a) ticks++;
    end
    check("rand_tick_budget", 32'(ticks), 10000);

    pause = 1'b0;
    level = 4'd0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lane_engine.md
LANE_ENGINE -- requirements
Module: lane_engine

Interface
REQ-001 SHALL take parameter NUM_LANES, default 8: number of independent traffic lanes (1..16).
REQ-002 SHALL take parameter X_W, default 10: width of each lane x-position.
REQ-003 SHALL take parameter SCREEN_W, default 640: horizontal wrap modulus in pixels.
REQ-004 SHALL take parameter STEP, default 2: pixels moved per lane step (1..SCREEN_W-1).
REQ-005 SHALL take parameter TICK_DIV, default 250000: CLK cycles per movement tick (>=2).
REQ-006 SHALL take parameter BASE_PERIOD, default 4: tick period of lane 0 at level 0.
REQ-007 SHALL take parameter START_SPACING, default 80: reset x-offset between adjacent lanes.
REQ-008 SHALL have one clock; reset is synchronous and active-high.
- CLK, input, 1: system clock.
- RST, input, 1: reset.
- pause, input, 1: freezes all motion and counters when 1.
- level, input, 4: difficulty; higher values shorten lane periods.
- lane_x, output, NUM_LANES*X_W: lane i position in bits [i*X_W +: X_W].
- step_mask, output, NUM_LANES: bit i pulses for one cycle when lane i moves.
- tick, output, 1: one-cycle pulse at each movement tick.

Function
REQ-009 SHALL run a prescaler counting 0..TICK_DIV-1; tick is 1 for exactly the cycle in which the count equals TICK_DIV-1, then the count returns to 0.
REQ-010 SHALL define lane i period P_i = max(1, BASE_PERIOD + (i mod 4) - level), evaluated combinationally each cycle.
REQ-011 SHALL keep a per-lane tick counter c_i that increments on tick; when tick and c_i+1 >= P_i, the lane steps and c_i clears to 0.
REQ-012 Use of >= (not ==) SHALL guarantee that a level increase mid-count causes a step on the next tick, never a missed wrap.
REQ-013 Even lanes SHALL move right: x' = x+STEP if x+STEP < SCREEN_W, else x+STEP-SCREEN_W.
REQ-014 Odd lanes SHALL move left: x' = x-STEP if x >= STEP, else x+SCREEN_W-STEP.
REQ-015 lane_x SHALL always lie in 0..SCREEN_W-1; intermediate arithmetic SHALL use X_W+1 bits.
REQ-016 step_mask[i] SHALL be registered and asserted in the cycle lane_x[i] shows the new value; latency from tick to new position is 1 cycle.
REQ-017 When pause=1: prescaler, c_i, and lane_x SHALL hold; tick=0; step_mask=0.
REQ-018 When pause falls, counting SHALL resume from the held values, with no extra or skipped tick.
REQ-019 Level changes SHALL take effect from the next tick; no other state is reset.

Reset
REQ-020 On RST=1 at a CLK edge: prescaler=0, all c_i=0, tick=0, step_mask=0, lane_x[i]=(i*START_SPACING) mod SCREEN_W.
REQ-021 RST SHALL override pause and any tick occurring in the same cycle.

Structure
REQ-022 SCREEN_W, default STEP, and default TICK_DIV SHALL be defined in the shared constants include, alongside the existing screen geometry.
REQ-023 One per-lane sub-module, lane_mover (counter, period compare, wrap, direction parameter), SHALL be instantiated NUM_LANES times via generate.
REQ-024 The prescaler SHALL live in lane_engine and drive tick into every lane_mover.

Verification
REQ-025 Bench SHALL use TICK_DIV=4, NUM_LANES=4, BASE_PERIOD=1, level=0. Reset, then run 4 cycles -> tick pulses at cycle 4; lane0 x moves 0→2; lane1 x moves 80→78; step_mask=0001 plus lanes whose period is reached.
REQ-026 Right wrap: force lane0 to 638 via its reset/start value, STEP=2 -> after its next step x=0; with STEP=3 from 638 -> x=1.
REQ-027 Left wrap: lane1 at x=1, STEP=2 -> x=639 after its step; x never exceeds 639 over 10,000 random ticks.
REQ-028 Level: level=0, lane3 P=4; raise level to 15 mid-count (c=2) -> lane3 steps on the very next tick, then every tick.
REQ-029 Pause: assert pause for 20 cycles spanning a tick -> no tick, no step_mask, lane_x unchanged; after release, first tick occurs exactly (TICK_DIV - held count) cycles later.
REQ-030 Reset mid-run with pause=1 and a coincident tick -> all lanes return to their start positions next cycle; step_mask=0.
